i2s_tx2: RTL
============

Name: i2s_tx2

Overview:
- I2S bus-master transmitter: two channels, 32-bit slots, 64 sck per frame.
- Generates ws and sd from sck for an external codec or the team's I2S receiver.
- Sample pairs arrive over a valid/ready handshake into a one-entry holding buffer, then load into the active pair at each frame boundary.
- Flags underrun when no pair is available at a frame boundary.

Parameters:
- N, 32, sample width in bits, legal range 1..32; data is MSB-first, left-justified in each 32-bit slot.

Ports:
- sck  input  1  bit clock; every register updates on the falling edge of sck.
- nrst  input  1  asynchronous, active-low reset.
- en  input  1  frame engine run enable; sampled on the falling edge of sck.
- chan0  input  N  left / ws-low channel sample.
- chan1  input  N  right / ws-high channel sample.
- in_valid  input  1  chan0 and chan1 hold a valid pair.
- in_ready  output  1  holding buffer empty; equals !pend_full (combinational).
- ws  output  1  word select, registered.
- sd  output  1  serial data, registered.
- underrun  output  1  one-cycle pulse on a frame load with no data.

Behaviour:
- Reset (async, nrst=0):
  - cnt=63, ws=0, sd=0, underrun=0.
  - pend_full=0, so in_ready=1.
  - Active pair and holding register cleared to 0.
  - Reset mid-frame aborts the frame immediately; any pending pair is discarded.
- Frame counter: cnt is 6 bits, wraps 63->0, advances one per falling edge while en=1.
  - Slot = cnt[5] (0 = chan0, 1 = chan1). Bit position p = cnt[4:0].
- Output timing (values registered at the edge where cnt takes value c):
  - ws = 1 for c in 31..62, else 0. ws therefore leads each slot by one bit, per I2S.
  - sd = active[slot][N-1-p] for p < N, else 0.
  - Receiver samples on the rising edge of sck.
- Handshake: a pair is accepted on a falling edge with in_valid & in_ready.
  - It is written to the holding register and sets pend_full.
- Frame load, at the edge where cnt advances 63->0 with en=1:
  - pend_full=1: the holding pair moves to the active pair and pend_full clears.
  - pend_full=0 and in_valid=1 on the same edge: the input pair bypasses directly into the active pair. pend_full stays 0 and there is no underrun.
  - pend_full=0 and in_valid=0: the active pair is set to zeros and underrun=1 for exactly this cycle.
  - sd at cnt=0 is the MSB of the newly loaded chan0, with no extra latency.
- en=0:
  - cnt holds at 63; ws and sd are driven 0; no underrun.
  - Handshake still fills the holding buffer.
  - When en goes 0->1, the first enabled edge is a frame load.
  - If en drops mid-frame, cnt jumps to 63 on that edge (frame truncated).
- Throughput: at most one pair per 64 sck. in_ready stays low from acceptance until the next frame load.

Decomposition:
- Package i2s_pkg holds:
  - SLOT_BITS=32, FRAME_BITS=64, LOAD_CNT=63.
  - WS_HIGH_FIRST=31, WS_HIGH_LAST=62.
- The I2S receiver shares this package.
- One sub-module: i2s_pair_buf, the one-entry holding buffer with valid/ready handshake and bypass. The counter, output mux and underrun logic stay in i2s_tx2.

Test Plan:
- Reset: nrst=0 mid-frame -> ws=0, sd=0, in_ready=1, underrun=0 immediately. With en=1 and no data, first edge -> underrun pulse, sd=0 for the whole frame.
- Single pair, N=32: chan0=0xA5A5_0F0F, chan1=0x8000_0001, then en=1.
  - ws low for 31 bits, high 32 bits, low again.
  - Captured via the team receiver: chan0=0xA5A5_0F0F, chan1=0x8000_0001.
  - MSB of chan0 appears one sck after ws falls.
- N=24: chan0=0xFFFFFF, chan1=0x123456 -> sd carries 24 data bits then 8 zeros per slot; receiver reconstructs both values.
- Back-to-back streaming: in_valid held high with incrementing pairs -> in_ready is high one cycle per frame; no pair lost or duplicated over 8 frames; underrun never asserts.
- Bypass corner: in_valid asserted first on the 63->0 edge with an empty buffer -> pair transmitted in that frame, underrun=0.
- Starvation: stop in_valid after 2 frames -> third frame is all zeros, underrun pulses exactly once per starved frame. Resuming in_valid -> next frame carries the new pair.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared I2S framing constants and helpers, used by the transmitter and the team receiver.
// Frame layout: 64 sck per frame, two 32-bit slots, ws leading each slot by one bit.
package i2s_pkg;

  localparam int SLOT_BITS  = 32;
  localparam int FRAME_BITS = 64;

  typedef logic [$clog2(FRAME_BITS)-1:0] frame_cnt_t;

  localparam frame_cnt_t LOAD_CNT      = 6'd63;
  localparam frame_cnt_t WS_HIGH_FIRST = 6'd31;
  localparam frame_cnt_t WS_HIGH_LAST  = 6'd62;

  // ws is high one bit early so it leads the ws-high slot by one sck
  function automatic logic ws_level(frame_cnt_t c);
    return (c >= WS_HIGH_FIRST) && (c <= WS_HIGH_LAST);
  endfunction

endpackage

// File: rtl/i2s_tx2_if.sv
// Sample-pair handshake between a producer (master) and the I2S transmitter (slave).
interface i2s_tx2_if #(
  parameter int N = 32
);
  logic [N-1:0] chan0;
  logic [N-1:0] chan1;
  logic         in_valid;
  logic         in_ready;

  modport master (output chan0, output chan1, output in_valid, input in_ready);
  modport slave  (input chan0, input chan1, input in_valid, output in_ready);
endinterface

// File: rtl/i2s_pair_buf.sv
// One-entry holding buffer for sample pairs; offers either the held pair or, when empty,
// the live input pair (bypass) to the frame loader.
module i2s_pair_buf #(
  parameter int N = 32
) (
  input  logic         sck,
  input  logic         nrst,
  input  logic         load,
  input  logic         in_valid,
  input  logic [N-1:0] chan0,
  input  logic [N-1:0] chan1,
  output logic         in_ready,
  output logic         pair_valid,
  output logic [N-1:0] pair0,
  output logic [N-1:0] pair1
);

  logic         pend_full_q, pend_full_d;
  logic [N-1:0] hold0_q, hold0_d;
  logic [N-1:0] hold1_q, hold1_d;

  // A load always empties the buffer: either the held pair leaves, or the input bypasses it
  always_comb begin
    pend_full_d = pend_full_q;
    hold0_d     = hold0_q;
    hold1_d     = hold1_q;
    if (load) begin
      pend_full_d = 1'b0;
    end else if (in_valid && !pend_full_q) begin
      pend_full_d = 1'b1;
      hold0_d     = chan0;
      hold1_d     = chan1;
    end
  end

  always_ff @(negedge sck or negedge nrst) begin
    if (!nrst) begin
      pend_full_q <= 1'b0;
      hold0_q     <= '0;
      hold1_q     <= '0;
    end else begin
      pend_full_q <= pend_full_d;
      hold0_q     <= hold0_d;
      hold1_q     <= hold1_d;
    end
  end

  assign in_ready   = !pend_full_q;
  assign pair_valid = pend_full_q | in_valid;
  assign pair0      = pend_full_q ? hold0_q : chan0;
  assign pair1      = pend_full_q ? hold1_q : chan1;

endmodule

// File: rtl/i2s_tx2.sv
// I2S bus-master transmitter: two left-justified N-bit channels in 32-bit slots,
// ws/sd launched on the falling edge of sck, underrun pulse on a starved frame load.
module i2s_tx2
  import i2s_pkg::*;
#(
  parameter int N = 32
) (
  input  logic     sck,
  input  logic     nrst,
  input  logic     en,
  i2s_tx2_if.slave bus,
  output logic     ws,
  output logic     sd,
  output logic     underrun
);

  frame_cnt_t   cnt_q, cnt_d;
  logic         ws_q, ws_d;
  logic         sd_q, sd_d;
  logic         underrun_q, underrun_d;
  logic [N-1:0] act0_q, act0_d;
  logic [N-1:0] act1_q, act1_d;

  logic         load;
  logic         pair_valid;
  logic [N-1:0] pair0, pair1;
  logic [N-1:0] sel;
  logic [SLOT_BITS-1:0] slot_word;

  assign load = en && (cnt_q == LOAD_CNT);

  i2s_pair_buf #(.N(N)) u_buf (
    .sck        (sck),
    .nrst       (nrst),
    .load       (load),
    .in_valid   (bus.in_valid),
    .chan0      (bus.chan0),
    .chan1      (bus.chan1),
    .in_ready   (bus.in_ready),
    .pair_valid (pair_valid),
    .pair0      (pair0),
    .pair1      (pair1)
  );

  // sd is taken from the next active pair and next count so bit 0 of a frame carries
  // the freshly loaded chan0 MSB without an extra cycle of latency
  always_comb begin
    cnt_d      = en ? cnt_q + 1'b1 : LOAD_CNT;
    act0_d     = act0_q;
    act1_d     = act1_q;
    underrun_d = 1'b0;
    if (load) begin
      act0_d     = pair_valid ? pair0 : '0;
      act1_d     = pair_valid ? pair1 : '0;
      underrun_d = !pair_valid;
    end
    sel       = cnt_d[5] ? act1_d : act0_d;
    slot_word = SLOT_BITS'(sel);
    slot_word = slot_word << (SLOT_BITS - N);
    ws_d      = en && ws_level(cnt_d);
    sd_d      = en && slot_word[~cnt_d[4:0]];
  end

  always_ff @(negedge sck or negedge nrst) begin
    if (!nrst) begin
      cnt_q      <= LOAD_CNT;
      ws_q       <= 1'b0;
      sd_q       <= 1'b0;
      underrun_q <= 1'b0;
      act0_q     <= '0;
      act1_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      ws_q       <= ws_d;
      sd_q       <= sd_d;
      underrun_q <= underrun_d;
      act0_q     <= act0_d;
      act1_q     <= act1_d;
    end
  end

  assign ws       = ws_q;
  assign sd       = sd_q;
  assign underrun = underrun_q;

endmodule
